// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst/response encodings, slave FSM states,
// and beat-size helper used by the slave-side write/read interfaces.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ASI_IDLE = 2'd0,
        ASI_DATA = 2'd1,
        ASI_RESP = 2'd2
    } asi_state_t;

    function automatic int unsigned beat_bytes(input logic [7:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; purely combinational.
// INCR realigns an unaligned start; WRAP folds back to the wrap window base.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int AXI_AW = 32,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3
) (
    input  logic [AXI_AW-1:0] addr,
    input  logic [AXI_SW-1:0] size,
    input  logic [AXI_LW-1:0] len,
    input  logic [1:0]        burst,
    output logic [AXI_AW-1:0] next_addr
);

    logic [AXI_AW-1:0] bytes;
    logic [AXI_AW-1:0] wsize;
    logic [AXI_AW-1:0] aligned;
    logic [AXI_AW-1:0] incr;
    logic [AXI_AW-1:0] low;

    always_comb begin
        bytes   = {{(AXI_AW-1){1'b0}}, 1'b1} << size;
        wsize   = bytes * (AXI_AW'(len) + AXI_AW'(1));
        aligned = addr & ~(bytes - AXI_AW'(1));
        incr    = aligned + bytes;
        low     = addr & ~(wsize - AXI_AW'(1));
        unique case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr;
            BURST_WRAP:  next_addr = (incr == low + wsize) ? low : incr;
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/asi_w.sv
// AXI write-side slave: one burst in flight, beats forwarded to a
// memory-style user port, one B response per burst.
module asi_w
    import axi_pkg::*;
#(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_WSTRBW = AXI_DW / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [AXI_IW-1:0]     AWID,
    input  logic [AXI_AW-1:0]     AWADDR,
    input  logic [AXI_LW-1:0]     AWLEN,
    input  logic [AXI_SW-1:0]     AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [AXI_DW-1:0]     WDATA,
    input  logic [AXI_WSTRBW-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [AXI_IW-1:0]     BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  usr_we,
    output logic [AXI_AW-1:0]     usr_waddr,
    output logic [AXI_DW-1:0]     usr_wdata,
    output logic [AXI_WSTRBW-1:0] usr_wstrb,
    input  logic                  usr_wready
);

    asi_state_t        state;
    logic [AXI_IW-1:0] id_q;
    logic [AXI_AW-1:0] addr_q;
    logic [AXI_LW-1:0] len_q;
    logic [AXI_SW-1:0] size_q;
    logic [1:0]        burst_q;
    logic [AXI_LW-1:0] beat_cc;
    logic              err;
    logic              bad_aw;

    logic              aw_hs;
    logic              hs;
    logic              last_beat;
    logic              last_err;
    logic              wrap_len_ok;
    logic              aw_illegal;
    logic [AXI_AW-1:0] next_addr;

    assign aw_hs     = AWVALID & AWREADY;
    assign WREADY    = (state == ASI_DATA) & usr_wready;
    assign hs        = WVALID & WREADY;
    assign last_beat = (beat_cc == len_q);
    assign last_err  = (WLAST != last_beat);

    assign usr_we    = hs & ~bad_aw;
    assign usr_waddr = addr_q;
    assign usr_wdata = WDATA;
    assign usr_wstrb = WSTRB;

    assign wrap_len_ok = (AWLEN == AXI_LW'(1)) || (AWLEN == AXI_LW'(3)) ||
                         (AWLEN == AXI_LW'(7)) || (AWLEN == AXI_LW'(15));
    assign aw_illegal  = (AWBURST == 2'b11) ||
                         (beat_bytes(8'(AWSIZE)) > AXI_WSTRBW) ||
                         ((AWBURST == BURST_WRAP) && !wrap_len_ok);

    axi_addr_gen #(
        .AXI_AW (AXI_AW),
        .AXI_LW (AXI_LW),
        .AXI_SW (AXI_SW)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= ASI_IDLE;
            AWREADY <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            beat_cc <= '0;
            err     <= 1'b0;
            bad_aw  <= 1'b0;
        end else begin
            unique case (state)
                ASI_IDLE: begin
                    if (aw_hs) begin
                        id_q    <= AWID;
                        addr_q  <= AWADDR;
                        len_q   <= AWLEN;
                        size_q  <= AWSIZE;
                        burst_q <= AWBURST;
                        beat_cc <= '0;
                        err     <= aw_illegal;
                        bad_aw  <= aw_illegal;
                        AWREADY <= 1'b0;
                        state   <= ASI_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                ASI_DATA: begin
                    if (hs) begin
                        beat_cc <= beat_cc + AXI_LW'(1);
                        addr_q  <= next_addr;
                        if (last_err) err <= 1'b1;
                        // Burst closes on beat count; WLAST only flags errors
                        if (last_beat) begin
                            BVALID <= 1'b1;
                            BID    <= id_q;
                            BRESP  <= (err | last_err) ? RESP_SLVERR : RESP_OKAY;
                            state  <= ASI_RESP;
                        end
                    end
                end
                ASI_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        state   <= ASI_IDLE;
                    end
                end
                default: state <= ASI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asi_w.sv
// Directed bench for asi_w: burst address sequences, error responses,
// stalls, back-pressure and reset in mid-burst.
module tb_asi_w;
    import axi_pkg::*;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [7:0]   AWID;
    logic [31:0]  AWADDR;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE;
    logic [1:0]   AWBURST;
    logic         AWVALID;
    logic         AWREADY;
    logic [127:0] WDATA;
    logic [15:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY;
    logic [7:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic         usr_we;
    logic [31:0]  usr_waddr;
    logic [127:0] usr_wdata;
    logic [15:0]  usr_wstrb;
    logic         usr_wready;

    int checks = 0;
    int errors = 0;

    logic [31:0]  wq[$];
    logic [127:0] dq[$];

    always #5 ACLK = ~ACLK;

    asi_w dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .AWID       (AWID),
        .AWADDR     (AWADDR),
        .AWLEN      (AWLEN),
        .AWSIZE     (AWSIZE),
        .AWBURST    (AWBURST),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .WLAST      (WLAST),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .BID        (BID),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .usr_we     (usr_we),
        .usr_waddr  (usr_waddr),
        .usr_wdata  (usr_wdata),
        .usr_wstrb  (usr_wstrb),
        .usr_wready (usr_wready)
    );

    // usr_we seen at negedge is a write committed on the next posedge
    always @(negedge ACLK) begin
        if (usr_we && !ARESET) begin
            wq.push_back(usr_waddr);
            dq.push_back(usr_wdata);
        end
    end

    task automatic send_aw(input logic [7:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt);
        int t;
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bt;
        AWVALID = 1'b1;
        t = 0;
        @(negedge ACLK);
        while (!AWREADY && t < 100) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL aw_timeout awready=%0b required 1", AWREADY);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input int n, input int last_at, input int stall_at);
        int t;
        for (int i = 0; i < n; i++) begin
            WVALID = 1'b1;
            WDATA  = {4{32'hA0 + 32'(i)}};
            WSTRB  = '1;
            WLAST  = (i == last_at);
            if (i == stall_at) begin
                usr_wready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge ACLK);
                    checks++;
                    if (WREADY !== 1'b0 || usr_we !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_wready wready=%0b we=%0b required 0/0",
                                 WREADY, usr_we);
                    end
                    @(posedge ACLK); #1;
                end
                usr_wready = 1'b1;
            end
            t = 0;
            @(negedge ACLK);
            while (!WREADY && t < 100) begin
                @(negedge ACLK);
                t++;
            end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL w_timeout wready=%0b required 1", WREADY);
            end
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic get_b(output logic [7:0] id, output logic [1:0] resp);
        int t;
        BREADY = 1'b1;
        t = 0;
        @(negedge ACLK);
        while (!BVALID && t < 100) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL b_timeout bvalid=%0b required 1", BVALID);
        end
        id   = BID;
        resp = BRESP;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        WVALID = 1'b1;
        usr_wready = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (AWREADY !== 1'b0 || BVALID !== 1'b0 || BID !== 8'h00 ||
            BRESP !== 2'b00 || WREADY !== 1'b0 || usr_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state aw=%0b bv=%0b bid=%h br=%b wr=%0b we=%0b required all 0",
                     AWREADY, BVALID, BID, BRESP, WREADY, usr_we);
        end
        WVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release awready=%0b required 1", AWREADY);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_incr;
        logic [31:0]  ea [4];
        logic [7:0]   id;
        logic [1:0]   rs;
        logic [127:0] ed;
        ea = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        wq.delete(); dq.delete();
        send_aw(8'h3C, 32'h1000, 8'd3, 3'd4, BURST_INCR);
        send_w(4, 3, -1);
        get_b(id, rs);
        checks++;
        if (wq.size() != 4) begin
            errors++;
            $display("FAIL incr_count writes=%0d required 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ed = {4{32'hA0 + 32'(i)}};
                checks++;
                if (wq[i] !== ea[i] || dq[i] !== ed) begin
                    errors++;
                    $display("FAIL incr_beat%0d addr=%h data=%h required %h/%h",
                             i, wq[i], dq[i], ea[i], ed);
                end
            end
        end
        checks++;
        if (id !== 8'h3C || rs !== RESP_OKAY) begin
            errors++;
            $display("FAIL incr_b bid=%h bresp=%b required 3c/00", id, rs);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] ea [4];
        logic [7:0]  id;
        logic [1:0]  rs;
        ea = '{32'h1034, 32'h1000, 32'h1010, 32'h1020};
        wq.delete(); dq.delete();
        send_aw(8'h11, 32'h1034, 8'd3, 3'd4, BURST_WRAP);
        send_w(4, 3, -1);
        get_b(id, rs);
        checks++;
        if (wq.size() != 4) begin
            errors++;
            $display("FAIL wrap_count writes=%0d required 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wq[i] !== ea[i]) begin
                    errors++;
                    $display("FAIL wrap_beat%0d addr=%h required %h", i, wq[i], ea[i]);
                end
            end
        end
        checks++;
        if (id !== 8'h11 || rs !== RESP_OKAY) begin
            errors++;
            $display("FAIL wrap_b bid=%h bresp=%b required 11/00", id, rs);
        end
    endtask

    task automatic test_unaligned;
        logic [31:0] ea [3];
        logic [7:0]  id;
        logic [1:0]  rs;
        ea = '{32'h2003, 32'h2004, 32'h2008};
        wq.delete(); dq.delete();
        send_aw(8'h22, 32'h2003, 8'd2, 3'd2, BURST_INCR);
        send_w(3, 2, -1);
        get_b(id, rs);
        checks++;
        if (wq.size() != 3) begin
            errors++;
            $display("FAIL unal_count writes=%0d required 3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[i] !== ea[i]) begin
                    errors++;
                    $display("FAIL unal_beat%0d addr=%h required %h", i, wq[i], ea[i]);
                end
            end
        end
        checks++;
        if (id !== 8'h22 || rs !== RESP_OKAY) begin
            errors++;
            $display("FAIL unal_b bid=%h bresp=%b required 22/00", id, rs);
        end
    endtask

    task automatic test_early_wlast;
        logic [7:0] id;
        logic [1:0] rs;
        wq.delete(); dq.delete();
        send_aw(8'h33, 32'h0800, 8'd3, 3'd4, BURST_INCR);
        send_w(4, 1, -1);
        get_b(id, rs);
        checks++;
        if (wq.size() != 4) begin
            errors++;
            $display("FAIL wlast_count writes=%0d required 4", wq.size());
        end
        checks++;
        if (id !== 8'h33 || rs !== RESP_SLVERR) begin
            errors++;
            $display("FAIL wlast_b bid=%h bresp=%b required 33/10", id, rs);
        end
    endtask

    task automatic test_bad_burst;
        logic [7:0] id;
        logic [1:0] rs;
        wq.delete(); dq.delete();
        send_aw(8'h44, 32'h0900, 8'd1, 3'd4, 2'b11);
        send_w(2, 1, -1);
        get_b(id, rs);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL bad_we writes=%0d required 0", wq.size());
        end
        checks++;
        if (id !== 8'h44 || rs !== RESP_SLVERR) begin
            errors++;
            $display("FAIL bad_b bid=%h bresp=%b required 44/10", id, rs);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ea [5];
        logic [7:0]  id;
        logic [1:0]  rs;
        ea = '{32'h3000, 32'h3010, 32'h3020, 32'h3030, 32'h4000};
        wq.delete(); dq.delete();
        send_aw(8'h05, 32'h3000, 8'd3, 3'd4, BURST_INCR);
        send_w(4, 3, 2);
        AWID = 8'h06; AWADDR = 32'h4000; AWLEN = 8'd0;
        AWSIZE = 3'd2; AWBURST = BURST_INCR; AWVALID = 1'b1;
        BREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b1 || BID !== 8'h05 || BRESP !== RESP_OKAY ||
                AWREADY !== 1'b0) begin
                errors++;
                $display("FAIL b_hold bv=%0b bid=%h br=%b awready=%0b required 1/05/00/0",
                         BVALID, BID, BRESP, AWREADY);
            end
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        checks++;
        if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin
            errors++;
            $display("FAIL aw_reopen awready=%0b bvalid=%0b required 1/0", AWREADY, BVALID);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        @(negedge ACLK);
        checks++;
        if (AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL aw_taken awready=%0b required 0", AWREADY);
        end
        @(posedge ACLK); #1;
        send_w(1, 0, -1);
        get_b(id, rs);
        checks++;
        if (id !== 8'h06 || rs !== RESP_OKAY) begin
            errors++;
            $display("FAIL b2b_b bid=%h bresp=%b required 06/00", id, rs);
        end
        checks++;
        if (wq.size() != 5) begin
            errors++;
            $display("FAIL b2b_count writes=%0d required 5", wq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wq[i] !== ea[i]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d addr=%h required %h", i, wq[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] id;
        logic [1:0] rs;
        send_aw(8'h07, 32'h5000, 8'd3, 3'd2, BURST_INCR);
        WVALID = 1'b1; WLAST = 1'b0; WDATA = '0; WSTRB = '1;
        @(negedge ACLK);
        checks++;
        if (usr_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_we_pre we=%0b required 1", usr_we);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        checks++;
        if (usr_we !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 ||
            AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset we=%0b wr=%0b bv=%0b aw=%0b required all 0",
                     usr_we, WREADY, BVALID, AWREADY);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        WVALID = 1'b0;
        wq.delete(); dq.delete();
        send_aw(8'h08, 32'h6000, 8'd0, 3'd4, BURST_FIXED);
        send_w(1, 0, -1);
        get_b(id, rs);
        checks++;
        if (wq.size() != 1 || id !== 8'h08 || rs !== RESP_OKAY) begin
            errors++;
            $display("FAIL post_reset writes=%0d bid=%h br=%b required 1/08/00",
                     wq.size(), id, rs);
        end else begin
            checks++;
            if (wq[0] !== 32'h6000) begin
                errors++;
                $display("FAIL post_reset_addr addr=%h required 6000", wq[0]);
            end
        end
    endtask

    initial begin
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
        WVALID = 1'b0; BREADY = 1'b0; usr_wready = 1'b1; ARESET = 1'b1;
        test_reset();
        test_incr();
        test_wrap();
        test_unaligned();
        test_early_wlast();
        test_bad_burst();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
